// File: rtl/iter_cu.sv
// Iteration control unit: sequences a load/run/complete cycle for a counted datapath
// and hands the result off with either an explicit acknowledge or a one-cycle pulse.
module iter_cu #(
    parameter int CNT_WIDTH = 4,
    parameter int MAX_N     = 12,
    parameter int AUTO_ACK  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_go,
    input  logic [CNT_WIDTH-1:0] i_n,
    input  logic                 i_abort,
    input  logic                 i_ack,
    output logic                 o_load_cnt,
    output logic                 o_mux_sel,
    output logic                 o_load_reg,
    output logic                 o_cnt_en,
    output logic                 o_buf_oe,
    output logic                 o_done,
    output logic                 o_error,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_iter_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // One extra bit so a MAX_N at the top of the operand range still compares correctly.
    localparam logic [CNT_WIDTH:0] LP_MAX_N   = (CNT_WIDTH + 1)'(MAX_N);
    localparam logic               LP_AUTO    = (AUTO_ACK != 0);
    localparam logic [CNT_WIDTH-1:0] LP_ONE   = CNT_WIDTH'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_range_err;
    logic                 w_cnt_gt1;
    logic                 w_release;

    assign w_range_err = ({1'b0, i_n} > LP_MAX_N);
    assign w_cnt_gt1   = (r_cnt > LP_ONE);
    assign w_release   = LP_AUTO | i_ack;

    // Abort freezes the counter; the next accepted start reloads it anyway.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_go) begin
                    if (w_range_err) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_LOAD;
                        w_cnt_next   = i_n;
                    end
                end
            end
            S_LOAD: begin
                w_state_next = i_abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_cnt_gt1) begin
                    w_cnt_next = r_cnt - LP_ONE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (w_release) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        o_load_cnt = 1'b0;
        o_mux_sel  = 1'b0;
        o_load_reg = 1'b0;
        o_cnt_en   = 1'b0;
        o_buf_oe   = 1'b0;
        o_done     = 1'b0;
        o_error    = 1'b0;
        o_busy     = 1'b0;
        case (r_state)
            S_LOAD: begin
                o_load_cnt = 1'b1;
                o_mux_sel  = 1'b1;
                o_load_reg = 1'b1;
                o_busy     = 1'b1;
            end
            S_RUN: begin
                o_busy     = 1'b1;
                o_cnt_en   = w_cnt_gt1;
                o_load_reg = w_cnt_gt1;
            end
            S_DONE: begin
                o_done   = 1'b1;
                o_buf_oe = 1'b1;
            end
            S_ERR: begin
                o_done  = 1'b1;
                o_error = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_iter_cnt = r_cnt;

endmodule
